mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Parametrised memory-mapped bridge between the single CPU load/store port and NUM_SLAVES peripherals (RAM, switches, LEDs, timers, …). Decodes each CPU access against a per-slave address window, drives a one-hot read/write strobe to the selected peripheral, waits for that peripheral's ready with a bounded timeout, and returns read data plus an error flag to the CPU. Supports variable wait states, unmapped-address errors, timeout errors and a sticky error-address capture register.

## Interface
- NUM_SLAVES, 4, number of peripheral ports (1–16)
- ADDR_W, 10, CPU byte-address width
- DATA_W, 32, data width; byte enables are DATA_W/8 wide
- SLV_BASE, {0x00,0x80,0x90,0xA0}, per-slave window base (byte address, aligned to window size)
- SLV_SIZE_LOG2, {7,4,4,4}, per-slave window size as log2 bytes
- TIMEOUT, 16, max ACCESS cycles before error; 0 disables timeout
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cpu_read / cpu_write  in  1 each  request; held stable until cpu_ready
- cpu_addr  in  ADDR_W  byte address
- cpu_be  in  DATA_W/8  byte enables
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  error qualifier, valid while cpu_ready
- err_addr  out  ADDR_W  byte address of most recent error (sticky)
- p_read / p_write  out  NUM_SLAVES each  one-hot strobes
- p_addr  out  ADDR_W-2  word address (byte address >> 2), registered
- p_be  out  DATA_W/8  registered byte enables
- p_wdata  out  DATA_W  registered write data
- p_rdata  in  NUM_SLAVES×DATA_W  per-slave read data
- p_ready  in  NUM_SLAVES  per-slave completion

## Operation
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- States IDLE → ACCESS → RESP → IDLE; IDLE → RESP directly on decode error.
- IDLE: on cpu_read|cpu_write, latch addr (>>2), be, wdata, direction, and decoded one-hot select.
- Decode: hit when (cpu_addr >> SLV_SIZE_LOG2[i]) == (SLV_BASE[i] >> SLV_SIZE_LOG2[i]); overlapping windows resolve to lowest index.
- Error in IDLE (go to RESP, no strobe, cpu_err=1, cpu_rdata=0): no window hit, or cpu_read and cpu_write both high.
- ACCESS: p_read or p_write bit of selected slave held high; counter increments each cycle. Only the selected slave's p_ready is honoured; others ignored.
- Selected p_ready high: capture p_rdata[sel] (reads) or 0 (writes), go RESP, cpu_err=0.
- Counter reaches TIMEOUT (TIMEOUT≠0) without ready: go RESP, cpu_err=1, cpu_rdata=0. Ready arriving in the timeout cycle wins (success).
- RESP: cpu_ready=1 for exactly one cycle, strobes 0; on error err_addr ← latched byte address.
- Reset mid-ACCESS: strobes drop on the next edge; no response issued.

## Timing
- Request sampled at edge 0; strobe high cycle 1; zero-wait slave (ready in cycle 1) → cpu_ready in cycle 2. Latency = 2 + wait states.
- Decode error: cpu_ready in cycle 1.
- Timeout: strobe high exactly TIMEOUT cycles; cpu_ready the cycle after.
- Strobes, p_addr, p_be, p_wdata registered; constant throughout ACCESS.
- Back-to-back: request still asserted in the IDLE cycle after RESP starts a new transaction; CPU drops request the cycle after cpu_ready to avoid repeat.

## Structure
- mmio_pkg: state enum (IDLE, ACCESS, RESP), default map constants, response struct {rdata, err}.
- Sub-module mmio_addr_decode: combinational, parameterised by SLV_BASE/SLV_SIZE_LOG2, outputs one-hot select and hit flag.

## Test plan
- Read 0x84 from slave1 (p_rdata[1]=0x1234_5678, zero-wait) → p_read=0b0010, p_addr=0x21, cpu_ready cycle 2, cpu_rdata=0x1234_5678, cpu_err=0.
- Write 0x94, be=0b0011, wdata=0xA5A5_A5A5, slave2 ready after 3 waits → p_write=0b0100 for 4 cycles, cpu_ready cycle 5, cpu_err=0.
- Read unmapped 0x3F0 → no strobe, cpu_ready cycle 1, cpu_err=1, cpu_rdata=0, err_addr=0x3F0.
- Read slave3 never ready, TIMEOUT=16 → strobe 16 cycles, then cpu_ready with cpu_err=1, err_addr=0xA0.
- Non-selected slave asserts p_ready during an ACCESS to slave0 → ignored; completion only on p_ready[0].
- rst_n low during ACCESS → strobes 0 next cycle, no cpu_ready, next access completes normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and default address map for the MMIO bridge.
//   state_t    : bridge FSM states (IDLE, ACCESS, RESP)
//   resp_t     : CPU response record {rdata, err} at the default bus width
//   DEF_*      : default four-slave map (RAM, switches, LEDs, timers)
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W = 32;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  err;
  } resp_t;

  // RAM at 0x00 (128 B), switches 0x80, LEDs 0x90, timers 0xA0 (16 B each)
  localparam int unsigned DEF_SLV_BASE      [4] = '{32'h00, 32'h80, 32'h90, 32'hA0};
  localparam int unsigned DEF_SLV_SIZE_LOG2 [4] = '{7, 4, 4, 4};

endpackage

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: combinational address window decoder.
//   addr : CPU byte address
//   sel  : one-hot slave select (lowest index wins on overlap)
//   hit  : at least one window matched
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int          NUM_SLAVES                      = 4,
  parameter int          ADDR_W                          = 10,
  parameter int unsigned SLV_BASE      [NUM_SLAVES]      = DEF_SLV_BASE,
  parameter int unsigned SLV_SIZE_LOG2 [NUM_SLAVES]      = DEF_SLV_SIZE_LOG2
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  // Scan from the highest index down so the lowest matching index is the
  // last assignment and therefore wins.
  always_comb begin
    sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr >> SLV_SIZE_LOG2[i]) ==
          (ADDR_W'(SLV_BASE[i]) >> SLV_SIZE_LOG2[i])) begin
        sel = NUM_SLAVES'(1) << i;
      end
    end
  end

  assign hit = |sel;

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: CPU load/store port to NUM_SLAVES memory-mapped peripherals.
//   clk, rst_n            : clock, synchronous active-low reset
//   cpu_read/cpu_write    : request, held until cpu_ready
//   cpu_addr/be/wdata     : byte address, byte enables, write data
//   cpu_rdata/ready/err   : one-cycle response pulse with data and error flag
//   err_addr              : byte address of the most recent failed access
//   p_read/p_write        : registered one-hot strobes to the selected slave
//   p_addr/p_be/p_wdata   : registered word address, byte enables, write data
//   p_rdata/p_ready       : per-slave read data (flattened) and completion
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int          NUM_SLAVES                 = 4,
  parameter int          ADDR_W                     = 10,
  parameter int          DATA_W                     = 32,
  parameter int unsigned SLV_BASE      [NUM_SLAVES] = DEF_SLV_BASE,
  parameter int unsigned SLV_SIZE_LOG2 [NUM_SLAVES] = DEF_SLV_SIZE_LOG2,
  parameter int          TIMEOUT                    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpu_read,
  input  logic                         cpu_write,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W/8-1:0]          cpu_be,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_ready,
  output logic                         cpu_err,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [NUM_SLAVES-1:0]        p_read,
  output logic [NUM_SLAVES-1:0]        p_write,
  output logic [ADDR_W-3:0]            p_addr,
  output logic [DATA_W/8-1:0]          p_be,
  output logic [DATA_W-1:0]            p_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] p_rdata,
  input  logic [NUM_SLAVES-1:0]        p_ready
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } bus_resp_t;

  state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_hit;
  logic [NUM_SLAVES-1:0] sel_q;
  logic                  wr_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_inc;
  bus_resp_t             resp_q;

  logic                  sel_ready;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  start_ok, start_err, done_ok, done_to;

  mmio_addr_decode #(
    .NUM_SLAVES    (NUM_SLAVES),
    .ADDR_W        (ADDR_W),
    .SLV_BASE      (SLV_BASE),
    .SLV_SIZE_LOG2 (SLV_SIZE_LOG2)
  ) u_decode (
    .addr (cpu_addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  assign cnt_inc = CNT_W'(cnt_q + 1'b1);

  // Only the latched target's ready and data are visible to the FSM; other
  // slaves may assert p_ready at any time without effect.
  always_comb begin
    sel_ready = |(p_ready & sel_q);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        sel_rdata = sel_rdata | p_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_err = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_read || cpu_write) begin
          if ((cpu_read && cpu_write) || !dec_hit) begin
            start_err = 1'b1;
            state_d   = RESP;
          end else begin
            start_ok  = 1'b1;
            state_d   = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Ready is tested first so a ready in the final timeout cycle succeeds.
        if (sel_ready) begin
          done_ok = 1'b1;
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
          done_to = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      resp_q   <= '0;
      err_addr <= '0;
      p_read   <= '0;
      p_write  <= '0;
      p_addr   <= '0;
      p_be     <= '0;
      p_wdata  <= '0;
    end else begin
      if (start_ok || start_err) begin
        addr_q  <= cpu_addr;
        p_addr  <= cpu_addr[ADDR_W-1:2];
        p_be    <= cpu_be;
        p_wdata <= cpu_wdata;
        wr_q    <= cpu_write;
        cnt_q   <= '0;
      end
      if (start_ok) begin
        sel_q   <= dec_sel;
        p_read  <= cpu_read  ? dec_sel : '0;
        p_write <= cpu_write ? dec_sel : '0;
      end
      if (start_err) begin
        sel_q    <= '0;
        resp_q   <= '{rdata: '0, err: 1'b1};
        err_addr <= cpu_addr;
      end
      if (state_q == ACCESS) begin
        cnt_q <= cnt_inc;
      end
      if (done_ok) begin
        resp_q  <= '{rdata: (wr_q ? '0 : sel_rdata), err: 1'b0};
        p_read  <= '0;
        p_write <= '0;
      end
      if (done_to) begin
        resp_q   <= '{rdata: '0, err: 1'b1};
        err_addr <= addr_q;
        p_read   <= '0;
        p_write  <= '0;
      end
      // Response is a single-cycle pulse; clear it so rdata/err read 0 otherwise.
      if (state_q == RESP) begin
        resp_q <= '0;
      end
    end
  end

  assign cpu_ready = (state_q == RESP);
  assign cpu_rdata = resp_q.rdata;
  assign cpu_err   = resp_q.err;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed self-checking bench for mmio_bridge (default map,
// TIMEOUT = 16). Each slave returns a fixed read pattern.
module tb_mmio_bridge;

  logic        clk;
  logic        rst_n;
  logic        cpu_read, cpu_write;
  logic [9:0]  cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic [9:0]  err_addr;
  logic [3:0]  p_read, p_write;
  logic [7:0]  p_addr;
  logic [3:0]  p_be;
  logic [31:0] p_wdata;
  logic [127:0] p_rdata;
  logic [3:0]  p_ready;

  int checks = 0;
  int errors = 0;

  assign p_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hDEAD_0000};

  mmio_bridge dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_be    (cpu_be),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .err_addr  (err_addr),
    .p_read    (p_read),
    .p_write   (p_write),
    .p_addr    (p_addr),
    .p_be      (p_be),
    .p_wdata   (p_wdata),
    .p_rdata   (p_rdata),
    .p_ready   (p_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic rd, input logic wr, input logic [9:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_be    = be;
    cpu_wdata = wd;
  endtask

  // Runs the request already on the CPU inputs until cpu_ready (max 40 cycles).
  // Slave rdy_slave asserts ready from cycle rdy_at on (0 = never); noise bits
  // assert ready on other slaves throughout.
  task automatic run_xfer(input int rdy_slave, input int rdy_at, input logic [3:0] noise,
                          output int lat, output int nrd, output int nwr,
                          output logic [31:0] rd, output logic er,
                          output logic [3:0] prd1, output logic [3:0] pwr1,
                          output logic [7:0] pa1, output logic [3:0] pbe1,
                          output logic [31:0] pwd1);
    logic [3:0] one;
    one = 4'b0001;
    lat = 0; nrd = 0; nwr = 0; rd = '0; er = 1'b0;
    prd1 = '0; pwr1 = '0; pa1 = '0; pbe1 = '0; pwd1 = '0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      p_ready = noise | (((rdy_at > 0) && (n >= rdy_at)) ? (one << rdy_slave) : 4'b0000);
      if (n == 1) begin
        prd1 = p_read; pwr1 = p_write; pa1 = p_addr; pbe1 = p_be; pwd1 = p_wdata;
      end
      if (p_read != 0)  nrd++;
      if (p_write != 0) nwr++;
      if (cpu_ready) begin
        lat = n; rd = cpu_rdata; er = cpu_err;
        break;
      end
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    p_ready   = '0;
    tick();
  endtask

  int          lat, nrd, nwr;
  logic [31:0] rd, pwd1;
  logic        er;
  logic [3:0]  prd1, pwr1, pbe1;
  logic [7:0]  pa1;

  initial begin
    rst_n = 1'b0;
    p_ready = '0;
    start(1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();
    check_eq("rst_ready", cpu_ready, 0);
    check_eq("rst_err",   cpu_err, 0);
    check_eq("rst_rdata", cpu_rdata, 0);
    check_eq("rst_strobe", {p_read, p_write}, 0);
    check_eq("rst_paddr", p_addr, 0);
    check_eq("rst_erraddr", err_addr, 0);
    rst_n = 1'b1;
    tick();

    // Zero-wait read from slave1
    start(1'b1, 1'b0, 10'h084, 4'hF, 32'h0);
    run_xfer(1, 1, 4'b0000, lat, nrd, nwr, rd, er, prd1, pwr1, pa1, pbe1, pwd1);
    check_eq("rd1_pread", prd1, 4'b0010);
    check_eq("rd1_paddr", pa1, 8'h21);
    check_eq("rd1_lat",   lat, 2);
    check_eq("rd1_rdata", rd, 32'h1234_5678);
    check_eq("rd1_err",   er, 0);
    check_eq("idle_ready", cpu_ready, 0);

    // Write to slave2 with 3 wait states
    start(1'b0, 1'b1, 10'h094, 4'b0011, 32'hA5A5_A5A5);
    run_xfer(2, 4, 4'b0000, lat, nrd, nwr, rd, er, prd1, pwr1, pa1, pbe1, pwd1);
    check_eq("wr2_pwrite", pwr1, 4'b0100);
    check_eq("wr2_pread",  prd1, 4'b0000);
    check_eq("wr2_paddr",  pa1, 8'h25);
    check_eq("wr2_pbe",    pbe1, 4'b0011);
    check_eq("wr2_pwdata", pwd1, 32'hA5A5_A5A5);
    check_eq("wr2_nstrobe", nwr, 4);
    check_eq("wr2_lat",    lat, 5);
    check_eq("wr2_rdata",  rd, 0);
    check_eq("wr2_err",    er, 0);

    // Unmapped read
    start(1'b1, 1'b0, 10'h3F0, 4'hF, 32'h0);
    run_xfer(0, 0, 4'b0000, lat, nrd, nwr, rd, er, prd1, pwr1, pa1, pbe1, pwd1);
    check_eq("unm_lat",    lat, 1);
    check_eq("unm_strobe", nrd + nwr, 0);
    check_eq("unm_err",    er, 1);
    check_eq("unm_rdata",  rd, 0);
    check_eq("unm_erraddr", err_addr, 10'h3F0);

    // Read and write asserted together
    start(1'b1, 1'b1, 10'h084, 4'hF, 32'h0);
    run_xfer(1, 1, 4'b0000, lat, nrd, nwr, rd, er, prd1, pwr1, pa1, pbe1, pwd1);
    check_eq("both_lat",    lat, 1);
    check_eq("both_strobe", nrd + nwr, 0);
    check_eq("both_err",    er, 1);
    check_eq("both_erraddr", err_addr, 10'h084);

    // Slave3 never ready: timeout
    start(1'b1, 1'b0, 10'h0A0, 4'hF, 32'h0);
    run_xfer(3, 0, 4'b0000, lat, nrd, nwr, rd, er, prd1, pwr1, pa1, pbe1, pwd1);
    check_eq("to_pread",   prd1, 4'b1000);
    check_eq("to_nstrobe", nrd, 16);
    check_eq("to_lat",     lat, 17);
    check_eq("to_err",     er, 1);
    check_eq("to_rdata",   rd, 0);
    check_eq("to_erraddr", err_addr, 10'h0A0);

    // Ready arriving in the final timeout cycle succeeds
    start(1'b1, 1'b0, 10'h0A4, 4'hF, 32'h0);
    run_xfer(3, 16, 4'b0000, lat, nrd, nwr, rd, er, prd1, pwr1, pa1, pbe1, pwd1);
    check_eq("edge_lat",   lat, 17);
    check_eq("edge_err",   er, 0);
    check_eq("edge_rdata", rd, 32'h3333_3333);
    check_eq("edge_erraddr", err_addr, 10'h0A0);

    // Other slaves assert ready during an access to slave0
    start(1'b1, 1'b0, 10'h010, 4'hF, 32'h0);
    run_xfer(0, 3, 4'b1110, lat, nrd, nwr, rd, er, prd1, pwr1, pa1, pbe1, pwd1);
    check_eq("nz_pread", prd1, 4'b0001);
    check_eq("nz_paddr", pa1, 8'h04);
    check_eq("nz_lat",   lat, 4);
    check_eq("nz_rdata", rd, 32'hDEAD_0000);
    check_eq("nz_err",   er, 0);

    // Reset in the middle of an access
    start(1'b1, 1'b0, 10'h084, 4'hF, 32'h0);
    tick();
    check_eq("mr_pread_on", p_read, 4'b0010);
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("mr_pread_off", p_read, 0);
    check_eq("mr_ready", cpu_ready, 0);
    check_eq("mr_erraddr", err_addr, 0);
    cpu_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("mr_idle_ready", cpu_ready, 0);
    start(1'b1, 1'b0, 10'h084, 4'hF, 32'h0);
    run_xfer(1, 1, 4'b0000, lat, nrd, nwr, rd, er, prd1, pwr1, pa1, pbe1, pwd1);
    check_eq("mr_next_lat",   lat, 2);
    check_eq("mr_next_rdata", rd, 32'h1234_5678);
    check_eq("mr_next_err",   er, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
